// File: rtl/mips_multicycle.sv
// Multicycle 32-bit MIPS core (add/sub/and/or/slt, addi, lw, sw, beq, j) with req/ack memories.
// Define MIPS_MC_PERF_EN to add the cycle_cnt / instret_cnt performance counters.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned WAIT_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
`ifdef MIPS_MC_PERF_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt,
`endif
    output logic        halted
);
    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [31:0] TMO_LAST = (WAIT_TIMEOUT == 0) ? 32'd0 : 32'(WAIT_TIMEOUT - 1);

    state_t             state;
    logic [31:0]        pc, ir, a, b, alu_out, mdr, target, wait_cnt;
    logic [31:0][31:0]  rf;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wr_idx;
    logic [31:0] sext_imm, alu_res;
    logic        legal, timeout;
    logic        unused_shamt;

    assign op        = ir[31:26];
    assign rs        = ir[25:21];
    assign rt        = ir[20:16];
    assign rd        = ir[15:11];
    assign funct     = ir[5:0];
    assign sext_imm  = {{16{ir[15]}}, ir[15:0]};
    assign wr_idx    = (op == OP_R) ? rd : rt;
    assign unused_shamt = ^ir[10:6];

    // A stall counts toward the timeout only when a limit is configured.
    assign timeout = (WAIT_TIMEOUT != 0) && (wait_cnt == TMO_LAST);

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_R: legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                          (funct == FN_OR)  || (funct == FN_SLT);
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = a + sext_imm;
        if (op == OP_R) begin
            case (funct)
                FN_ADD:  alu_res = a + b;
                FN_SUB:  alu_res = a - b;
                FN_AND:  alu_res = a & b;
                FN_OR:   alu_res = a | b;
                FN_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
                default: alu_res = a + b;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_RESET;
            pc       <= RESET_PC;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            alu_out  <= '0;
            mdr      <= '0;
            target   <= '0;
            wait_cnt <= '0;
            rf       <= '0;
        end else begin
            wait_cnt <= '0;
            case (state)
                S_RESET: state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_data;
                        pc    <= pc + 32'd4;
                        state <= S_DECODE;
                    end else if (timeout) begin
                        state <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_DECODE: begin
                    a      <= rf[rs];
                    b      <= rf[rt];
                    target <= pc + {sext_imm[29:0], 2'b00};
                    if (op == OP_J) begin
                        pc    <= {pc[31:28], ir[25:0], 2'b00};
                        state <= S_FETCH;
                    end else if (!legal) begin
                        state <= S_ERROR;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    case (op)
                        OP_BEQ: begin
                            if (a == b) pc <= target;
                            state <= S_FETCH;
                        end
                        // Misaligned accesses trap before any request is issued.
                        OP_LW, OP_SW: state <= (alu_res[1:0] != 2'b00) ? S_ERROR : S_MEM;
                        default:      state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (op == OP_LW) begin
                            mdr   <= dmem_rdata;
                            state <= S_WB;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else if (timeout) begin
                        state <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_WB: begin
                    if (wr_idx != 5'd0) rf[wr_idx] <= (op == OP_LW) ? mdr : alu_out;
                    state <= S_FETCH;
                end
                S_ERROR: state <= S_ERROR;
                default: state <= S_ERROR;
            endcase
        end
    end

    assign imem_req   = (state == S_FETCH);
    assign imem_addr  = pc;
    assign dmem_req   = (state == S_MEM);
    assign dmem_we    = dmem_req && (op == OP_SW);
    assign dmem_addr  = alu_out;
    assign dmem_wdata = b;
    assign halted     = (state == S_ERROR);

`ifdef MIPS_MC_PERF_EN
    logic retire;
    assign retire = ((state == S_DECODE) && (op == OP_J)) ||
                    ((state == S_EXEC) && (op == OP_BEQ)) ||
                    ((state == S_MEM) && dmem_ack && (op == OP_SW)) ||
                    (state == S_WB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != S_RESET && state != S_ERROR) cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: program run, stalls, branches, traps and fetch timeout.
module tb_mips_multicycle;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
    logic [31:0] imem_addr, imem_data, dmem_addr, dmem_wdata, dmem_rdata;
    logic        imem_req_t, dmem_req_t, dmem_we_t, halted_t;
    logic [31:0] imem_addr_t, dmem_addr_t, dmem_wdata_t;
`ifdef MIPS_MC_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt, cycle_cnt_t, instret_cnt_t;
`endif

    logic [31:0] imem [0:127];
    logic [31:0] dmem [0:15];
    int imem_lat = 0;
    int dmem_lat = 3;
    int icnt = 0;
    int dcnt = 0;
    int cyc  = 0;

    mips_multicycle #(.RESET_PC(32'h0), .WAIT_TIMEOUT(0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
`ifdef MIPS_MC_PERF_EN
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
        .halted(halted)
    );

    mips_multicycle #(.RESET_PC(32'h0), .WAIT_TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst),
        .imem_req(imem_req_t), .imem_addr(imem_addr_t), .imem_ack(1'b0), .imem_data(32'h0),
        .dmem_req(dmem_req_t), .dmem_we(dmem_we_t), .dmem_addr(dmem_addr_t), .dmem_wdata(dmem_wdata_t),
        .dmem_ack(1'b0), .dmem_rdata(32'h0),
`ifdef MIPS_MC_PERF_EN
        .cycle_cnt(cycle_cnt_t), .instret_cnt(instret_cnt_t),
`endif
        .halted(halted_t)
    );

    assign imem_ack   = imem_req && (icnt >= imem_lat);
    assign imem_data  = imem[imem_addr[8:2]];
    assign dmem_ack   = dmem_req && (dcnt >= dmem_lat);
    assign dmem_rdata = dmem[dmem_addr[5:2]];

    always @(posedge clk) begin
        icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[5:2]] <= dmem_wdata;
        cyc <= cyc + 1;
    end

    // Log of accepted fetches, plus store-phase stability and data-request activity.
    logic [31:0] f_addr [$];
    int          f_cyc  [$];
    logic [31:0] f_ir   [$];
    logic [31:0] f_cc   [$];
    int sw_cycles = 0;
    int sw_bad    = 0;
    int n_dreq    = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (imem_req && imem_ack) begin
                f_addr.push_back(imem_addr);
                f_cyc.push_back(cyc);
`ifdef MIPS_MC_PERF_EN
                f_ir.push_back(instret_cnt);
                f_cc.push_back(cycle_cnt);
`endif
            end
            if (dmem_req) begin
                n_dreq++;
                if (dmem_we) begin
                    sw_cycles++;
                    if (dmem_addr !== 32'd8 || dmem_wdata !== 32'd2) sw_bad++;
                end
            end
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    logic [31:0] exp_addr [0:10];
    int          exp_gap  [0:9];

    initial begin
        int nreq;
        int d0;
        bit seen;
        for (int i = 0; i < 128; i++) imem[i] = 32'h0;
        for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
        imem[0]  = 32'h2001_0005; // addi $1,$0,5
        imem[1]  = 32'h2002_FFFD; // addi $2,$0,-3
        imem[2]  = 32'h0022_1820; // add  $3,$1,$2
        imem[3]  = 32'h0041_202A; // slt  $4,$2,$1
        imem[4]  = 32'hAC03_0008; // sw   $3,8($0)
        imem[5]  = 32'h8C05_0008; // lw   $5,8($0)
        imem[6]  = 32'h1022_0005; // beq  $1,$2,+5 (not taken)
        imem[7]  = 32'h0800_0040; // j    0x40 -> 0x100
        imem[64] = 32'h1021_FFFF; // beq  $1,$1,-1 (self loop)
        exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h100, 32'h100, 32'h100};
        exp_gap  = '{4, 4, 4, 4, 7, 8, 3, 2, 3, 3};

        repeat (3) @(negedge clk);
        chk("rst_imem_req",  {31'd0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_dmem_req",  {31'd0, dmem_req}, 32'd0);
        chk("rst_dmem_we",   {31'd0, dmem_we}, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_dmem_wdata", dmem_wdata, 32'h0);
        chk("rst_halted",    {31'd0, halted}, 32'd0);

        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("first_fetch_req",  {31'd0, imem_req}, 32'd1);
                chk("first_fetch_addr", imem_addr, 32'h0);
                chk("first_halted",     {31'd0, halted}, 32'd0);
            end
            if (k == 4) begin
                chk("to_req_k4",    {31'd0, imem_req_t}, 32'd1);
                chk("to_halted_k4", {31'd0, halted_t}, 32'd0);
            end
            if (k == 5) begin
                chk("to_halted_k5", {31'd0, halted_t}, 32'd1);
                chk("to_req_k5",    {31'd0, imem_req_t}, 32'd0);
`ifdef MIPS_MC_PERF_EN
                chk("to_cycle_k5",   cycle_cnt_t, 32'd4);
                chk("to_instret_k5", instret_cnt_t, 32'd0);
`endif
            end
            if (k == 8) begin
                chk("to_halted_k8", {31'd0, halted_t}, 32'd1);
`ifdef MIPS_MC_PERF_EN
                chk("to_cycle_frozen", cycle_cnt_t, 32'd4);
`endif
            end
        end

        for (int t = 0; t < 300 && f_addr.size() < 11; t++) @(negedge clk);
        if (f_addr.size() < 11) begin
            chk("fetch_log_timeout", 32'(f_addr.size()), 32'd11);
        end else begin
            for (int i = 0; i < 11; i++) chk($sformatf("fetch_addr_%0d", i), f_addr[i], exp_addr[i]);
            for (int i = 0; i < 10; i++) chk($sformatf("latency_%0d", i), 32'(f_cyc[i+1] - f_cyc[i]), 32'(exp_gap[i]));
`ifdef MIPS_MC_PERF_EN
            chk("perf_instret", f_ir[8], 32'd8);
            chk("perf_cycle",   f_cc[8], 32'd36);
`endif
        end
        chk("reg1", dut.rf[1], 32'd5);
        chk("reg2", dut.rf[2], 32'hFFFF_FFFD);
        chk("reg3", dut.rf[3], 32'd2);
        chk("reg4", dut.rf[4], 32'd1);
        chk("reg5", dut.rf[5], 32'd2);
        chk("dmem8", dmem[2], 32'd2);
        chk("sw_hold_cycles", 32'(sw_cycles), 32'd4);
        chk("sw_hold_stable", 32'(sw_bad), 32'd0);

        // Reset while a fetch is pending: the request must drop at once.
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = imem_req;
        end
        chk("loop_fetch_seen", {31'd0, seen}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_req_drop", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", imem_addr, 32'h0);
        chk("rst_rf_clear", dut.rf[3], 32'd0);

        imem[0] = 32'hFC00_0000; // illegal opcode
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("illegal_halted", {31'd0, halted}, 32'd1);
        nreq = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (imem_req || dmem_req) nreq++;
        end
        chk("illegal_no_req", 32'(nreq), 32'd0);

        rst = 1'b0;
        imem[0] = 32'h8C05_0006; // lw $5,6($0), misaligned
        @(negedge clk);
        chk("rst_clears_halt", {31'd0, halted}, 32'd0);
        d0 = n_dreq;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("misalign_halted", {31'd0, halted}, 32'd1);
        nreq = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (imem_req || dmem_req) nreq++;
        end
        chk("misalign_no_req", 32'(nreq), 32'd0);
        chk("misalign_no_dreq", 32'(n_dreq - d0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
